program_memory_loader: RTL and testbench
========================================

Name: program_memory_loader

Overview:
- Instruction memory that sits directly upstream of the instruction fetch stage.
- The fetch stage presents a 14-bit word address; this block returns the 32-bit instruction at that address.
- It also contains a byte-stream loader (UART-receiver side) that writes a new program into memory while the CPU is held.
- Single clock domain; memory contents are not reset.

Parameters:
ADDR_WIDTH, 14, word-address width; matches the fetch address width.
DEPTH, 16384, number of 32-bit words; must equal 2**ADDR_WIDTH or be smaller.

Ports:
iCpuClock  input  1  system clock; all state updates on the rising edge.
iCpuReset  input  1  asynchronous, active-high reset.
iFetchAddr  input  ADDR_WIDTH  word address from the fetch stage (PC[15:2]).
oInstruction  output  32  instruction read from memory.
iLoadEnable  input  1  level; high requests or continues a program load.
iByteValid  input  1  one-cycle strobe; iByteData is valid this cycle.
iByteData  input  8  program byte, most significant byte of each word first.
oCpuHold  output  1  high while loading; the top level ORs it into the CPU reset.
oLoadDone  output  1  one-cycle pulse when a load session ends.
oLoadError  output  1  sticky error flag, cleared at the start of the next load.
oWordCount  output  ADDR_WIDTH+1  number of words written in the current or last session.

Behaviour:
- Reset (asynchronous, while iCpuReset=1): state=IDLE, byte counter=0, word address=0, assembly register=0.
- Output reset values: oInstruction=0, oCpuHold=0, oLoadDone=0, oLoadError=0, oWordCount=0.
- Memory array is untouched by reset. Reset mid-load aborts the session; words already written are kept.
- Read path, IDLE state: oInstruction <= mem[iFetchAddr] on every rising edge (1-cycle latency).
  - Fetch updates the PC on the falling edge, so the instruction is valid before the next falling edge.
- Read path, any state other than IDLE: oInstruction <= 0 (NOP).
- IDLE:
  - If iLoadEnable=1: go to LOAD; clear byte counter, word address, oWordCount and oLoadError; oCpuHold <= 1.
  - iByteValid is ignored in IDLE.
- LOAD:
  - A byte is accepted only when iByteValid=1 and iLoadEnable=1 in the same cycle.
  - Each accepted byte is shifted into the assembly register: asm <= {asm[23:0], iByteData}. Byte counter increments modulo 4.
  - On the 4th byte: mem[wordAddr] <= {asm[23:0], iByteData}; wordAddr++; oWordCount++.
  - The 4th-byte write completes in the same cycle the byte is accepted.
  - If that write was to DEPTH-1: go to DRAIN.
  - If iLoadEnable=0: go to FINISH. If byte counter != 0, set oLoadError; the partial word is discarded, not written.
- DRAIN (memory full):
  - No writes; any iByteValid=1 sets oLoadError.
  - Go to FINISH when iLoadEnable=0.
- FINISH:
  - Lasts exactly one cycle: oLoadDone=1, oCpuHold=1.
  - Next state is IDLE, and oCpuHold drops to 0 in that cycle.
- oCpuHold=1 in the states LOAD, DRAIN and FINISH.
- Word address wraps neither past DEPTH-1 nor back to 0; the width of oWordCount allows the value DEPTH.
- If iLoadEnable rises again in the cycle after FINISH, a new session starts from IDLE normally.
- Writes use a synchronous single-write-port array; this must be inferable as block RAM.

Test Plan:
- Reset then idle read: preload mem[0..3] by load, assert iCpuReset mid-cycle -> all outputs 0 asynchronously, mem retained; with iFetchAddr=2 the next edge gives oInstruction=mem[2].
- Load 8 bytes 0x20,0x08,0x00,0x05,0x00,0x00,0x00,0x00, then drop iLoadEnable:
  - mem[0]=0x20080005, mem[1]=0x00000000.
  - oWordCount=2, one oLoadDone pulse, oLoadError=0, oCpuHold high from the cycle after the enable to the FINISH cycle.
- Partial word: load 6 bytes then drop enable -> oWordCount=1, mem[1] unchanged, oLoadError=1.
  - The next session clears oLoadError at its start.
- Full memory (DEPTH=4 build): send 20 bytes -> words 0..3 written, state DRAIN after the 16th byte, oLoadError=1 from the 17th byte, oWordCount=4.
- Byte strobe coincident with iLoadEnable falling -> byte not accepted; byte counter and memory unchanged.
- Reset asserted during LOAD after 5 bytes -> state IDLE, oCpuHold=0, mem[0] holds the first word, next read of address 0 returns it.

Source files
------------

// File: rtl/program_memory_loader.sv
// Instruction memory feeding fetch, with a byte-stream program loader.
// Bytes arrive MSB-first; the CPU is held while a new image is written.
module program_memory_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 16384
) (
    input  logic                  iCpuClock,
    input  logic                  iCpuReset,
    input  logic [ADDR_WIDTH-1:0] iFetchAddr,
    output logic [31:0]           oInstruction,
    input  logic                  iLoadEnable,
    input  logic                  iByteValid,
    input  logic [7:0]            iByteData,
    output logic                  oCpuHold,
    output logic                  oLoadDone,
    output logic                  oLoadError,
    output logic [ADDR_WIDTH:0]   oWordCount
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [23:0]           asm_q, asm_d;
    logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
    logic                  err_q, err_d;
    logic [31:0]           instr_q;
    logic                  we;
    logic [31:0]           wdata;
    logic                  fetch_ok;

    logic [31:0] mem [DEPTH];

    assign fetch_ok = ({1'b0, iFetchAddr} < DEPTH_W);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        waddr_d    = waddr_q;
        asm_d      = asm_q;
        wcount_d   = wcount_q;
        err_d      = err_q;
        we         = 1'b0;
        wdata      = {asm_q, iByteData};
        unique case (state_q)
            S_IDLE: begin
                if (iLoadEnable) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 2'd0;
                    waddr_d    = '0;
                    wcount_d   = '0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (!iLoadEnable) begin
                    // A partially assembled word is dropped, never written.
                    state_d = S_FINISH;
                    if (byte_cnt_q != 2'd0) err_d = 1'b1;
                end else if (iByteValid) begin
                    asm_d      = {asm_q[15:0], iByteData};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we       = 1'b1;
                        wcount_d = wcount_q + 1'b1;
                        if (waddr_q == LAST) state_d = S_DRAIN;
                        else waddr_d = waddr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (iByteValid) err_d = 1'b1;
                if (!iLoadEnable) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            waddr_q    <= '0;
            asm_q      <= '0;
            wcount_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            waddr_q    <= waddr_d;
            asm_q      <= asm_d;
            wcount_q   <= wcount_d;
            err_q      <= err_d;
        end
    end

    // Contents survive reset so an image loaded before reset still runs.
    always_ff @(posedge iCpuClock) begin
        if (we) mem[waddr_q[MAW-1:0]] <= wdata;
    end

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            instr_q <= '0;
        end else if (state_q == S_IDLE && fetch_ok) begin
            instr_q <= mem[iFetchAddr[MAW-1:0]];
        end else begin
            instr_q <= '0;
        end
    end

    assign oInstruction = instr_q;
    assign oCpuHold     = (state_q != S_IDLE);
    assign oLoadDone    = (state_q == S_FINISH);
    assign oLoadError   = err_q;
    assign oWordCount   = wcount_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader on a 4-word build: table sessions,
// corner-case sequences and random sessions against a byte-list model.
module tb_program_memory_loader;

    localparam int AW = 4;
    localparam int DP = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] fa;
    logic [31:0]   oInstruction;
    logic          en;
    logic          bv;
    logic [7:0]    bd;
    logic          oCpuHold;
    logic          oLoadDone;
    logic          oLoadError;
    logic [AW:0]   oWordCount;

    program_memory_loader #(.ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .iCpuClock   (clk),
        .iCpuReset   (rst),
        .iFetchAddr  (fa),
        .oInstruction(oInstruction),
        .iLoadEnable (en),
        .iByteValid  (bv),
        .iByteData   (bd),
        .oCpuHold    (oCpuHold),
        .oLoadDone   (oLoadDone),
        .oLoadError  (oLoadError),
        .oWordCount  (oWordCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         n;
        logic [7:0] base;
        int         wc;
        bit         err;
    } vec_t;

    int          errors;
    int          checks;
    int          done_seen;
    logic [7:0]  bq[$];
    logic [31:0] mm[DP];
    bit          mv[DP];
    int          exp_wc;
    bit          exp_err;
    vec_t        tbl[8];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (oLoadDone) done_seen++;
    endtask

    // Model: the session's accepted bytes, grouped four at a time.
    task automatic model_apply();
        int n;
        int nw;
        n  = bq.size();
        nw = n / 4;
        if (nw > DP) nw = DP;
        for (int w = 0; w < nw; w++) begin
            mm[w] = {bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]};
            mv[w] = 1'b1;
        end
        exp_wc  = nw;
        exp_err = (n > 4 * DP) || (n % 4 != 0);
    endtask

    task automatic run_session(input bit gaps, input string tag);
        int d0;
        d0 = done_seen;
        en = 1'b1;
        bv = 1'b0;
        tick();
        check({tag, " hold0"}, {31'b0, oCpuHold}, 1);
        check({tag, " errclr"}, {31'b0, oLoadError}, 0);
        check({tag, " wcclr"}, 32'(oWordCount), 0);
        foreach (bq[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bv = 1'b0;
                tick();
            end
            bv = 1'b1;
            bd = bq[i];
            tick();
        end
        bv = 1'b0;
        en = 1'b0;
        tick();
        check({tag, " done"}, {31'b0, oLoadDone}, 1);
        check({tag, " holdF"}, {31'b0, oCpuHold}, 1);
        check({tag, " nop"}, oInstruction, 0);
        check({tag, " wc"}, 32'(oWordCount), 32'(exp_wc));
        check({tag, " err"}, {31'b0, oLoadError}, {31'b0, exp_err});
        tick();
        check({tag, " holdI"}, {31'b0, oCpuHold}, 0);
        check({tag, " pulses"}, 32'(done_seen - d0), 1);
        check({tag, " errS"}, {31'b0, oLoadError}, {31'b0, exp_err});
    endtask

    task automatic rd(input int a);
        fa = AW'(a);
        tick();
        if (mv[a]) check($sformatf("rd%0d", a), oInstruction, mm[a]);
    endtask

    task automatic rd_all();
        for (int a = 0; a < DP; a++) rd(a);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        done_seen = 0;
        for (int a = 0; a < DP; a++) mv[a] = 1'b0;
        tbl[0] = '{8,  8'h10, 2, 1'b0};
        tbl[1] = '{6,  8'h40, 1, 1'b1};
        tbl[2] = '{0,  8'h00, 0, 1'b0};
        tbl[3] = '{3,  8'h60, 0, 1'b1};
        tbl[4] = '{4,  8'h70, 1, 1'b0};
        tbl[5] = '{16, 8'h80, 4, 1'b0};
        tbl[6] = '{19, 8'hA0, 4, 1'b1};
        tbl[7] = '{12, 8'hC0, 3, 1'b0};

        rst = 1'b1;
        en  = 1'b0;
        bv  = 1'b0;
        bd  = 8'h00;
        fa  = '0;
        #3;
        check("rst instr", oInstruction, 0);
        check("rst hold", {31'b0, oCpuHold}, 0);
        check("rst done", {31'b0, oLoadDone}, 0);
        check("rst err", {31'b0, oLoadError}, 0);
        check("rst wc", 32'(oWordCount), 0);
        #9;
        rst = 1'b0;
        tick();

        bq = {8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        model_apply();
        run_session(1'b0, "prog");
        fa = AW'(0);
        tick();
        check("prog m0", oInstruction, 32'h20080005);
        fa = AW'(1);
        tick();
        check("prog m1", oInstruction, 32'h00000000);

        for (int t = 0; t < 8; t++) begin
            bq.delete();
            for (int i = 0; i < tbl[t].n; i++) bq.push_back(tbl[t].base + 8'(i));
            model_apply();
            exp_wc  = tbl[t].wc;
            exp_err = tbl[t].err;
            run_session(1'b1, $sformatf("tbl%0d", t));
            rd_all();
        end

        // Memory full: DRAIN after the 16th byte, error from the 17th.
        bq.delete();
        for (int i = 0; i < 20; i++) bq.push_back(8'(8'h31 * i + 7));
        model_apply();
        en = 1'b1;
        bv = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            bv = 1'b1;
            bd = bq[i];
            tick();
            if (i == 15) begin
                check("full wc16", 32'(oWordCount), 4);
                check("full err16", {31'b0, oLoadError}, 0);
                check("full hold16", {31'b0, oCpuHold}, 1);
            end
            if (i == 16) check("full err17", {31'b0, oLoadError}, 1);
        end
        bv = 1'b0;
        en = 1'b0;
        tick();
        check("full done", {31'b0, oLoadDone}, 1);
        check("full wc", 32'(oWordCount), 4);
        check("full err", {31'b0, oLoadError}, 1);
        tick();
        rd_all();

        // Fourth byte strobed as enable falls must not be taken.
        en = 1'b1;
        bv = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bv = 1'b1;
            bd = 8'hE0 + 8'(i);
            tick();
        end
        en = 1'b0;
        bv = 1'b1;
        bd = 8'hEF;
        tick();
        bv = 1'b0;
        check("coin done", {31'b0, oLoadDone}, 1);
        check("coin wc", 32'(oWordCount), 0);
        check("coin err", {31'b0, oLoadError}, 1);
        tick();
        rd(0);

        // Asynchronous reset while idle: outputs clear, memory kept.
        rd(1);
        fa = AW'(2);
        #2;
        rst = 1'b1;
        #1;
        check("arst instr", oInstruction, 0);
        check("arst err", {31'b0, oLoadError}, 0);
        check("arst hold", {31'b0, oCpuHold}, 0);
        #1;
        rst = 1'b0;
        tick();
        check("arst m2", oInstruction, mm[2]);

        // Reset after five bytes of a load aborts it; word 0 remains.
        bq = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12};
        en = 1'b1;
        bv = 1'b0;
        tick();
        foreach (bq[i]) begin
            bv = 1'b1;
            bd = bq[i];
            tick();
        end
        bv = 1'b0;
        check("mid hold", {31'b0, oCpuHold}, 1);
        check("mid wc", 32'(oWordCount), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst hold", {31'b0, oCpuHold}, 0);
        check("mid rst wc", 32'(oWordCount), 0);
        check("mid rst done", {31'b0, oLoadDone}, 0);
        en = 1'b0;
        #1;
        rst = 1'b0;
        mm[0] = 32'hDEADBEEF;
        fa = AW'(0);
        tick();
        check("mid m0", oInstruction, 32'hDEADBEEF);
        rd_all();

        for (int s = 0; s < 12; s++) begin
            int n;
            n = $urandom_range(0, 20);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
            model_apply();
            run_session(1'b1, $sformatf("rnd%0d", s));
            for (int k = 0; k < 6; k++) rd($urandom_range(0, DP - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
